sme_dom_gate: RTL and testbench

SME_DOM_GATE -- requirements
Module: sme_dom_gate

---
 rtl/sme_pkg.sv | 31 +++
 rtl/sme_dom_gate_row.sv | 66 ++++++
 rtl/sme_dom_gate.sv | 114 +++++++++++
 tb/tb_sme_dom_gate.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and helpers for the domain-oriented masked gate.
// The guard-word index is shared by the top and the bench-facing ports.
package sme_pkg;

   typedef enum logic [1:0] {
      SME_AND  = 2'd0,
      SME_OR   = 2'd1,
      SME_XOR  = 2'd2,
      SME_ANDN = 2'd3
   } sme_dom_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_CMP,
      ST_DONE
   } sme_dom_st_t;

   function automatic int rmax(input int d);
      return d * (d - 1) / 2;
   endfunction

   function automatic int gidx(input int s, input int p);
      int lo;
      int hi;
      lo = (s < p) ? s : p;
      hi = (s < p) ? p : s;
      return lo + hi * (hi - 1) / 2;
   endfunction

endpackage

// File: rtl/sme_dom_gate_row.sv
// One share row: D registered product terms and a registered
// compression of those terms into the row's output share.
module sme_dom_gate_row
   import sme_pkg::*;
#(
   parameter int D = 3,
   parameter int N = 32,
   parameter int S = 0
) (
   input  logic                  g_clk,
   input  logic                  g_reset,
   input  logic                  clr_term,
   input  logic                  clr_out,
   input  logic                  ld_term,
   input  logic                  ld_out,
   input  logic                  xor_mode,
   input  logic                  inv_out,
   input  logic [N-1:0]          x,
   input  logic [D-1:0][N-1:0]   y,
   input  logic [D-1:0][N-1:0]   g,
   output logic [N-1:0]          rd_s
);

   logic [D-1:0][N-1:0] term_d;
   logic [D-1:0][N-1:0] term_q;
   logic [N-1:0]        sum;

   // g[S] is tied to zero by the top, so the diagonal term stays unguarded
   always_comb begin
      term_d = '0;
      for (int p = 0; p < D; p++) begin
         if (xor_mode) begin
            term_d[p] = (p == S) ? (x ^ y[p]) : '0;
         end else begin
            term_d[p] = (x & y[p]) ^ g[p];
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int p = 0; p < D; p++) begin
         sum = sum ^ term_q[p];
      end
      if (inv_out && (S == 0)) begin
         sum = ~sum;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset || clr_term) begin
         term_q <= '0;
      end else if (ld_term) begin
         term_q <= term_d;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset || clr_out) begin
         rd_s <= '0;
      end else if (ld_out) begin
         rd_s <= sum;
      end
   end

endmodule

// File: rtl/sme_dom_gate.sv
// Masked AND/OR/XOR/ANDN gate over D Boolean shares with fresh
// guard words; fixed latency and rng use regardless of operation.
module sme_dom_gate
   import sme_pkg::*;
#(
   parameter int D = 3,
   parameter int N = 32,
   localparam int RMAX = rmax(D)
) (
   input  logic                    g_clk,
   input  logic                    g_reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  sme_dom_op_t             op,
   input  logic [D-1:0][N-1:0]     rs1,
   input  logic [D-1:0][N-1:0]     rs2,
   input  logic [RMAX-1:0][N-1:0]  rng,
   input  logic                    rng_valid,
   output logic                    rng_ack,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [D-1:0][N-1:0]     rd,
   output logic                    busy
);

   sme_dom_st_t state_q;
   sme_dom_st_t state_d;

   logic accept;
   logic or_q;
   logic ld_out;
   logic clr_out;

   logic [D-1:0][N-1:0]         x_pre;
   logic [D-1:0][N-1:0]         y_pre;
   logic [D-1:0][D-1:0][N-1:0]  gsel;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = rng_valid && !g_reset;
            if (in_valid && rng_valid) state_d = ST_MUL;
         end
         ST_MUL:  state_d = ST_CMP;
         ST_CMP:  state_d = ST_DONE;
         ST_DONE: if (rd_ready) state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   assign accept   = in_valid && in_ready && !flush;
   assign rng_ack  = accept;
   assign rd_valid = (state_q == ST_DONE) && !g_reset;
   assign busy     = (state_q != ST_IDLE) && !g_reset;
   assign ld_out   = (state_q == ST_CMP);
   assign clr_out  = flush || ((state_q == ST_DONE) && rd_ready);

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= ST_IDLE;
         or_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) or_q <= (op == SME_OR);
      end
   end

   // OR is computed as ~(~a & ~b) on share 0
   always_comb begin
      x_pre = rs1;
      y_pre = rs2;
      if (op == SME_OR) begin
         x_pre[0] = ~rs1[0];
         y_pre[0] = ~rs2[0];
      end
      if (op == SME_ANDN) begin
         y_pre[0] = ~rs2[0];
      end
   end

   always_comb begin
      gsel = '0;
      for (int s = 0; s < D; s++) begin
         for (int p = 0; p < D; p++) begin
            if (s != p) gsel[s][p] = rng[gidx(s, p)];
         end
      end
   end

   for (genvar s = 0; s < D; s++) begin : g_row
      sme_dom_gate_row #(
         .D (D),
         .N (N),
         .S (s)
      ) u_row (
         .g_clk    (g_clk),
         .g_reset  (g_reset),
         .clr_term (flush),
         .clr_out  (clr_out),
         .ld_term  (accept),
         .ld_out   (ld_out),
         .xor_mode (op == SME_XOR),
         .inv_out  (or_q),
         .x        (x_pre[s]),
         .y        (y_pre),
         .g        (gsel[s]),
         .rd_s     (rd[s])
      );
   end

endmodule

// File: tb/tb_sme_dom_gate.sv
// Randomized self-checking bench for sme_dom_gate against an
// unmasked reference of the gate's Boolean function.
module tb_sme_dom_gate;
   import sme_pkg::*;

   localparam int D    = 3;
   localparam int N    = 32;
   localparam int RMAX = D * (D - 1) / 2;

   logic                    g_clk = 1'b0;
   logic                    g_reset;
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   sme_dom_op_t             op;
   logic [D-1:0][N-1:0]     rs1;
   logic [D-1:0][N-1:0]     rs2;
   logic [RMAX-1:0][N-1:0]  rng;
   logic                    rng_valid;
   logic                    rng_ack;
   logic                    rd_valid;
   logic                    rd_ready;
   logic [D-1:0][N-1:0]     rd;
   logic                    busy;

   int checks   = 0;
   int failures = 0;

   always #5 g_clk = ~g_clk;

   sme_dom_gate #(.D(D), .N(N)) dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rs1       (rs1),
      .rs2       (rs2),
      .rng       (rng),
      .rng_valid (rng_valid),
      .rng_ack   (rng_ack),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd        (rd),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   function automatic logic [N-1:0] ref_op(input sme_dom_op_t o,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
      case (o)
         SME_AND:  return a & b;
         SME_OR:   return a | b;
         SME_XOR:  return a ^ b;
         default:  return a & ~b;
      endcase
   endfunction

   function automatic logic [D-1:0][N-1:0] share(input logic [N-1:0] v);
      logic [D-1:0][N-1:0] s;
      logic [N-1:0] acc;
      acc = v;
      for (int i = 0; i < D - 1; i++) begin
         s[i] = $urandom;
         acc  = acc ^ s[i];
      end
      s[D-1] = acc;
      return s;
   endfunction

   function automatic logic [N-1:0] unmask(input logic [D-1:0][N-1:0] s);
      logic [N-1:0] acc;
      acc = '0;
      for (int i = 0; i < D; i++) acc = acc ^ s[i];
      return acc;
   endfunction

   function automatic logic [RMAX-1:0][N-1:0] rand_rng();
      logic [RMAX-1:0][N-1:0] r;
      for (int i = 0; i < RMAX; i++) r[i] = $urandom;
      return r;
   endfunction

   task automatic run_op(input sme_dom_op_t o, input logic [N-1:0] a,
                         input logic [N-1:0] b, input int stall,
                         input int hold, input bit rz);
      logic [D-1:0][N-1:0] held;
      logic [N-1:0] exp;
      int n;
      exp       = ref_op(o, a, b);
      rs1       = share(a);
      rs2       = share(b);
      op        = o;
      in_valid  = 1'b1;
      rng_valid = 1'b0;
      rng       = rz ? '0 : rand_rng();
      for (int i = 0; i < stall; i++) begin
         #1;
         check("stall_rdy", in_ready, 0);
         check("stall_ack", rng_ack, 0);
         tick();
         check("stall_busy", busy, 0);
      end
      rng_valid = 1'b1;
      #1;
      check("acc_rdy", in_ready, 1);
      check("acc_ack", rng_ack, 1);
      tick();
      in_valid  = 1'b0;
      rng_valid = 1'b0;
      rs1       = share($urandom);
      rs2       = share($urandom);
      rng       = rz ? '0 : rand_rng();
      check("mul_busy", busy, 1);
      check("mul_ack", rng_ack, 0);
      n = 0;
      while (!rd_valid && n < 6) begin
         tick();
         n++;
      end
      check("latency", n, 2);
      check("result", unmask(rd), exp);
      held      = rd;
      in_valid  = 1'b1;
      rng_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         #1;
         check("hold_rdy", in_ready, 0);
         tick();
         check("hold_rd", rd, held);
         check("hold_valid", rd_valid, 1);
      end
      rd_ready = 1'b1;
      #1;
      check("hs_rdy", in_ready, 0);
      tick();
      rd_ready  = 1'b0;
      in_valid  = 1'b0;
      rng_valid = 1'b0;
      check("post_rd", rd, 0);
      check("post_valid", rd_valid, 0);
      check("post_busy", busy, 0);
   endtask

   initial begin
      g_reset   = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      rng_valid = 1'b1;
      rd_ready  = 1'b0;
      op        = SME_AND;
      rs1       = '0;
      rs2       = '0;
      rng       = '0;
      repeat (3) tick();
      check("rst_rdy", in_ready, 0);
      check("rst_ack", rng_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_rd", rd, 0);
      in_valid  = 1'b0;
      rng_valid = 1'b0;
      g_reset   = 1'b0;
      tick();

      run_op(SME_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 1'b0);
      run_op(SME_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 1'b0);
      run_op(SME_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 1'b0);
      run_op(SME_ANDN, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 1'b0);
      check("vec_and", ref_op(SME_AND, 32'hF0F0_1234, 32'h0FF0_FFFF),
            32'h00F0_1234);
      run_op(SME_AND,  32'hA5A5_5A5A, 32'h3C3C_C3C3, 5, 0, 1'b0);
      run_op(SME_OR,   32'h1234_5678, 32'h8765_4321, 0, 4, 1'b0);

      // flush in the MUL cycle
      rs1       = share(32'hDEAD_BEEF);
      rs2       = share(32'hFFFF_0000);
      rng       = rand_rng();
      op        = SME_AND;
      in_valid  = 1'b1;
      rng_valid = 1'b1;
      tick();
      in_valid  = 1'b0;
      rng_valid = 1'b0;
      check("fl_mul_busy", busy, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_busy", busy, 0);
      check("fl_rd", rd, 0);
      for (int i = 0; i < 4; i++) begin
         check("fl_valid", rd_valid, 0);
         tick();
      end

      // flush beats acceptance
      in_valid  = 1'b1;
      rng_valid = 1'b1;
      flush     = 1'b1;
      #1;
      check("flp_ack", rng_ack, 0);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      rng_valid = 1'b0;
      check("flp_busy", busy, 0);

      // reset in CMP
      in_valid  = 1'b1;
      rng_valid = 1'b1;
      tick();
      in_valid  = 1'b0;
      rng_valid = 1'b0;
      tick();
      g_reset = 1'b1;
      #1;
      check("rc_busy", busy, 0);
      check("rc_rdy", in_ready, 0);
      tick();
      check("rc_rd", rd, 0);
      g_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rc_valid", rd_valid, 0);
         check("rc_idle", busy, 0);
         tick();
      end

      run_op(SME_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 1'b1);
      run_op(SME_OR,  32'h0000_00FF, 32'h00FF_0000, 0, 1, 1'b1);

      for (int k = 0; k < 24; k++) begin
         run_op(sme_dom_op_t'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
